// File: rtl/tcm_pmem_arbiter.sv
// Single-port TCM arbiter: shares one RAM port between the CPU core port and a
// single-beat AXI slave, with fixed core priority bounded by a starvation limit.
module tcm_pmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_wr_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wdata_i,
   input  logic [3:0]  core_wstrb_i,
   output logic        core_accept_o,
   output logic        core_rvalid_o,
   output logic [31:0] core_rdata_o,
   input  logic        axi_awvalid_i,
   input  logic [31:0] axi_awaddr_i,
   output logic        axi_awready_o,
   input  logic        axi_wvalid_i,
   input  logic [31:0] axi_wdata_i,
   input  logic [3:0]  axi_wstrb_i,
   output logic        axi_wready_o,
   output logic        axi_bvalid_o,
   input  logic        axi_bready_i,
   input  logic        axi_arvalid_i,
   input  logic [31:0] axi_araddr_i,
   output logic        axi_arready_o,
   output logic        axi_rvalid_o,
   output logic [31:0] axi_rdata_o,
   input  logic        axi_rready_i,
   output logic        ram_en_o,
   output logic [3:0]  ram_wr_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, WR_RESP, RD_DATA} axi_state_t;

   axi_state_t    axi_state_reg, axi_state_next;
   logic [CW-1:0] starve_cnt_reg, starve_cnt_next;
   logic          last_axi_reg, last_axi_next;     // 0 = write, 1 = read
   logic          rd_pend_reg, rd_pend_next;
   logic          rd_cap_reg, rd_cap_next;
   logic [31:0]   rdata_reg;

   logic wr_elig, rd_elig, axi_elig, pick_rd, axi_grant, core_grant;

   always_comb begin
      wr_elig    = !rst_i && (axi_state_reg == IDLE) && axi_awvalid_i && axi_wvalid_i;
      rd_elig    = !rst_i && (axi_state_reg == IDLE) && axi_arvalid_i;
      axi_elig   = wr_elig || rd_elig;
      // Round-robin only matters when both types are eligible.
      pick_rd    = rd_elig && (!wr_elig || !last_axi_reg);
      axi_grant  = axi_elig && (!core_req_i || (starve_cnt_reg == LIMIT));
      core_grant = !rst_i && core_req_i && !axi_grant;
   end

   always_comb begin
      axi_state_next  = axi_state_reg;
      starve_cnt_next = starve_cnt_reg;
      last_axi_next   = last_axi_reg;
      rd_pend_next    = 1'b0;
      rd_cap_next     = 1'b0;
      axi_awready_o   = 1'b0;
      axi_wready_o    = 1'b0;
      axi_arready_o   = 1'b0;
      core_accept_o   = 1'b0;
      ram_en_o        = 1'b0;
      ram_wr_o        = 4'h0;
      ram_addr_o      = core_addr_i;
      ram_wdata_o     = core_wdata_i;

      case (axi_state_reg)
         WR_RESP: if (axi_bready_i) axi_state_next = IDLE;
         RD_DATA: if (axi_rready_i) axi_state_next = IDLE;
         default: axi_state_next = axi_state_reg;
      endcase

      if (axi_grant) begin
         ram_en_o = 1'b1;
         if (pick_rd) begin
            axi_arready_o  = 1'b1;
            ram_addr_o     = axi_araddr_i;
            axi_state_next = RD_DATA;
            last_axi_next  = 1'b1;
            rd_cap_next    = 1'b1;
         end else begin
            axi_awready_o  = 1'b1;
            axi_wready_o   = 1'b1;
            ram_wr_o       = axi_wstrb_i;
            ram_addr_o     = axi_awaddr_i;
            ram_wdata_o    = axi_wdata_i;
            axi_state_next = WR_RESP;
            last_axi_next  = 1'b0;
         end
      end else if (core_grant) begin
         core_accept_o = 1'b1;
         if (core_wr_i) begin
            // A strobe-less write is still taken from the core but never touches the RAM.
            ram_en_o = |core_wstrb_i;
            ram_wr_o = core_wstrb_i;
         end else begin
            ram_en_o     = 1'b1;
            rd_pend_next = 1'b1;
         end
      end

      if (!axi_elig || axi_grant)
         starve_cnt_next = '0;
      else if (core_grant && (starve_cnt_reg != LIMIT))
         starve_cnt_next = starve_cnt_reg + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         axi_state_reg  <= IDLE;
         starve_cnt_reg <= '0;
         last_axi_reg   <= 1'b0;
         rd_pend_reg    <= 1'b0;
         rd_cap_reg     <= 1'b0;
         rdata_reg      <= 32'h0;
      end else begin
         axi_state_reg  <= axi_state_next;
         starve_cnt_reg <= starve_cnt_next;
         last_axi_reg   <= last_axi_next;
         rd_pend_reg    <= rd_pend_next;
         rd_cap_reg     <= rd_cap_next;
         if (rd_cap_reg) rdata_reg <= ram_rdata_i;
      end
   end

   // In the first RD_DATA cycle the RAM output is live; afterwards the held copy is used.
   assign axi_rdata_o   = rd_cap_reg ? ram_rdata_i : rdata_reg;
   assign axi_rvalid_o  = (axi_state_reg == RD_DATA);
   assign axi_bvalid_o  = (axi_state_reg == WR_RESP);
   assign core_rvalid_o = rd_pend_reg;
   assign core_rdata_o  = ram_rdata_i;

endmodule

// File: doc/tcm_pmem_arbiter.md
Name: tcm_pmem_arbiter

Overview:
- Single-port arbiter and sequencer for a TCM RAM (1-cycle read latency). Shared between the CPU instruction/data core port and an AXI slave port (single-beat, no bursts).
- Core has fixed priority, bounded by a starvation limit that guarantees AXI a slot.
- Drives the RAM enable, byte-write strobes, address and write data. Owns all AXI handshake and response registers.

Parameters:
- STARVE_LIMIT, 4: max consecutive cycles the core may win while an AXI request is eligible; must be >= 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- core_req_i  in  1  core access request
- core_wr_i  in  1  1 = write, 0 = read
- core_addr_i  in  32  core byte address
- core_wdata_i  in  32  core write data
- core_wstrb_i  in  4  core byte strobes
- core_accept_o  out  1  core request taken this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  32  core read data
- axi_awvalid_i / axi_awaddr_i[32] / axi_awready_o  AXI write address channel
- axi_wvalid_i / axi_wdata_i[32] / axi_wstrb_i[4] / axi_wready_o  AXI write data channel
- axi_bvalid_o / axi_bready_i  AXI write response channel; response is always OKAY
- axi_arvalid_i / axi_araddr_i[32] / axi_arready_o  AXI read address channel
- axi_rvalid_o / axi_rdata_o[32] / axi_rready_i  AXI read data channel
- ram_en_o  out  1  RAM access this cycle
- ram_wr_o  out  4  byte write enables; 0 = read
- ram_addr_o  out  32  RAM byte address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after a read

Behaviour:
- Reset values (all registers, asynchronous): axi_state=IDLE, axi_bvalid_o=0, axi_rvalid_o=0, axi_rdata_o=0, core_rvalid_o=0, core read-pending=0, AXI read-capture=0, starve_cnt=0, last_axi=0 (write).
- Reset mid-operation: outstanding B/R responses and core read returns are discarded. No valid is asserted after reset deassertion until a new request is accepted.
- AXI FSM states:
  - IDLE: AXI eligible if (awvalid && wvalid) or arvalid. If both are eligible, round-robin on last_axi: pick the type opposite to the last one served.
  - WR_RESP: axi_bvalid_o=1. Go to IDLE on bready.
  - RD_DATA: axi_rvalid_o=1. Go to IDLE on rready.
  - No AXI acceptance outside IDLE. The core is unaffected.
- Grant (combinational from the registered state; one RAM access per cycle):
  - AXI wins if AXI is eligible and (!core_req_i or starve_cnt == STARVE_LIMIT). Otherwise the core wins if core_req_i.
  - starve_cnt increments when core wins with AXI eligible. It clears when AXI is granted or AXI is not eligible. It saturates at STARVE_LIMIT.
- AXI write grant:
  - awready = wready = 1 in the same cycle.
  - ram_en=1, ram_wr=axi_wstrb_i, ram_addr=awaddr, ram_wdata=wdata.
  - Next state WR_RESP, so bvalid rises the next cycle. last_axi=write.
- AXI read grant:
  - arready=1, ram_en=1, ram_wr=0, ram_addr=araddr.
  - Next state RD_DATA. rdata is captured from ram_rdata_i only in the first RD_DATA cycle (capture flag), then held stable until rready. last_axi=read.
- Core grant:
  - core_accept_o=1, ram_en=1, ram_addr=core_addr_i.
  - Write: ram_wr=core_wstrb_i, ram_wdata=core_wdata_i. A write with wstrb=0 is accepted but ram_en=0.
  - Read: ram_wr=0. core_rvalid_o=1 exactly one cycle later with core_rdata_o=ram_rdata_i. No core backpressure.
- Idle cycles: ram_en=0, ram_wr=0, ram_addr=core_addr_i, ram_wdata=core_wdata_i.
- Simultaneous awvalid without wvalid (or the reverse): the write is not eligible, and no ready is asserted.
- Latency: core read 1 cycle. AXI read: arready to rvalid 1 cycle. AXI write: handshake to bvalid 1 cycle.

Test Plan:
- Reset with axi_arvalid_i=1, core_req_i=0 -> during and right after reset rvalid=0, ram_en=0. First rvalid is one cycle after arready.
- Core read 0x100 alone -> core_accept=1, ram_en=1, ram_wr=0. Next cycle core_rvalid=1 with RAM data.
- AXI write 0x40 data 0xDEADBEEF strb 0xF, bready held 0 for 3 cycles -> one RAM write. bvalid=1 held for 3 cycles. No second accept while bvalid.
- core_req_i stuck at 1 with arvalid=1, STARVE_LIMIT=4 -> core wins 4 cycles, then arready in the 5th cycle. starve_cnt returns to 0.
- awvalid+wvalid and arvalid together, core idle, rready/bready=1 -> grants alternate read, write, read... and last_axi toggles.
- AXI read in RD_DATA with rready=0 while the core reads other addresses -> axi_rdata_o stays equal to the first captured value. The core returns its own data.
